// File: rtl/isram_pkg.sv
// rtl/isram_pkg.sv - shared state, size codes and alignment check for the instruction-SRAM controller
package isram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_RD = 2'd1,
        LD_RSP = 2'd2,
        ST_WR  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Size code 3 has no meaning and is rejected together with misaligned accesses.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] adr_lo);
        return (size == 2'd3) ||
               ((size == SZ_H) && adr_lo[0]) ||
               ((size == SZ_W) && (adr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/isram_ctrl_if.sv
// rtl/isram_ctrl_if.sv - fetch and load/store request bus into the instruction-SRAM controller
interface isram_ctrl_if;

    logic        isram_cs;
    logic [28:0] isram_adr;
    logic [63:0] instr_fromsram;

    logic        lsu_req;
    logic        lsu_we;
    logic [31:0] lsu_adr;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_err;

    logic        lr_isram_cs;
    logic        lr_isram_cs_ff;

    modport master (
        output isram_cs, isram_adr,
        output lsu_req, lsu_we, lsu_adr, lsu_size, lsu_unsigned, lsu_wdata,
        input  instr_fromsram, lsu_rdata, lsu_done, lsu_err,
        input  lr_isram_cs, lr_isram_cs_ff
    );

    modport slave (
        input  isram_cs, isram_adr,
        input  lsu_req, lsu_we, lsu_adr, lsu_size, lsu_unsigned, lsu_wdata,
        output instr_fromsram, lsu_rdata, lsu_done, lsu_err,
        output lr_isram_cs, lr_isram_cs_ff
    );

endinterface

// File: rtl/isram_lane_merge.sv
// rtl/isram_lane_merge.sv - byte-lane extraction for loads and lane replacement for read-modify-write stores
module isram_lane_merge
    import isram_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  adr,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [63:0] merge_word
);

    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic [63:0] lane_mask;
    logic        unused_hi;

    assign shamt     = {adr, 3'b000};
    assign shifted   = word >> shamt;
    assign unused_hi = ^shifted[63:32];

    // Pick the addressed lanes and extend them; the mask marks the same lanes for the store merge.
    always_comb begin
        load_data = shifted[31:0];
        lane_mask = 64'h0000_0000_FFFF_FFFF;
        case (size)
            SZ_B: begin
                load_data = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
                lane_mask = 64'h0000_0000_0000_00FF;
            end
            SZ_H: begin
                load_data = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
                lane_mask = 64'h0000_0000_0000_FFFF;
            end
            default: ;
        endcase
    end

    assign merge_word = (word & ~(lane_mask << shamt)) |
                        (({32'd0, wdata} & lane_mask) << shamt);

endmodule

// File: rtl/isram_ctrl.sv
// rtl/isram_ctrl.sv - fetch responder and LSU arbiter for a single-port 64-bit instruction SRAM
module isram_ctrl
    import isram_pkg::*;
#(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          cpurst,
    isram_ctrl_if.slave   bus,
    output logic          sram_ce,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [63:0]   sram_wdata,
    input  logic [63:0]   sram_rdata
);

    state_t        state;
    logic          fetch_own;
    logic          lr_q;
    logic          lr_ff_q;
    logic          done_q;
    logic          err_q;
    logic [63:0]   instr_hold;
    logic [31:0]   load_data;
    logic [63:0]   merge_word;
    logic [AW-1:0] fetch_word;
    logic [AW-1:0] lsu_word;
    logic          misaligned;
    logic          unused_adr_bits;

    assign fetch_word      = bus.isram_adr[AW-1:0];
    assign lsu_word        = bus.lsu_adr[AW+2:3];
    assign unused_adr_bits = ^{bus.isram_adr[28:AW], bus.lsu_adr[31:AW+3]};
    assign misaligned      = is_misaligned(bus.lsu_size, bus.lsu_adr[1:0]);

    isram_lane_merge u_lane (
        .word       (sram_rdata),
        .adr        (bus.lsu_adr[2:0]),
        .size       (bus.lsu_size),
        .zero_ext   (bus.lsu_unsigned),
        .wdata      (bus.lsu_wdata),
        .load_data  (load_data),
        .merge_word (merge_word)
    );

    // Ownership FSM; a request seen in the misaligned done cycle is the one just answered, so it is ignored.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            state     <= IDLE;
            lr_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fetch_own <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fetch_own <= 1'b0;
            case (state)
                IDLE: begin
                    fetch_own <= bus.isram_cs;
                    if (bus.lsu_req && !done_q) begin
                        if (misaligned) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state <= ACC_RD;
                            lr_q  <= 1'b1;
                        end
                    end
                end
                ACC_RD: begin
                    state  <= bus.lsu_we ? ST_WR : LD_RSP;
                    done_q <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    lr_q  <= 1'b0;
                end
            endcase
        end
    end

    // Delayed ownership flag lets fetch see the cycle ownership was taken.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            lr_ff_q <= 1'b0;
        end else begin
            lr_ff_q <= lr_q;
        end
    end

    // Keep the last fetched word so fetch still sees it while the LSU owns the macro.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            instr_hold <= '0;
        end else if (fetch_own) begin
            instr_hold <= sram_rdata;
        end
    end

    // Macro port steering: fetch address in IDLE, LSU address while the LSU owns the macro.
    always_comb begin
        sram_ce   = 1'b0;
        sram_we   = 1'b0;
        sram_addr = fetch_word;
        if (!cpurst) begin
            case (state)
                IDLE: sram_ce = bus.isram_cs;
                ACC_RD: begin
                    sram_ce   = 1'b1;
                    sram_addr = lsu_word;
                end
                ST_WR: begin
                    sram_ce   = 1'b1;
                    sram_we   = 1'b1;
                    sram_addr = lsu_word;
                end
                default: sram_addr = lsu_word;
            endcase
        end
    end

    assign sram_wdata         = merge_word;
    assign bus.instr_fromsram = fetch_own ? sram_rdata : instr_hold;
    assign bus.lsu_rdata      = (state == LD_RSP) ? load_data : 32'd0;
    assign bus.lsu_done       = done_q;
    assign bus.lsu_err        = err_q;
    assign bus.lr_isram_cs    = lr_q;
    assign bus.lr_isram_cs_ff = lr_ff_q;

endmodule

// File: tb/tb_isram_ctrl.sv
// tb/tb_isram_ctrl.sv - randomized self-checking bench for isram_ctrl against a byte-level memory model
module tb_isram_ctrl;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          cpurst;
    logic          sram_ce;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [63:0]   sram_wdata;
    logic [63:0]   sram_rdata = '0;

    isram_ctrl_if bus();

    isram_ctrl #(.AW(AW)) dut (
        .clk        (clk),
        .cpurst     (cpurst),
        .bus        (bus),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    logic [63:0]   mem [0:(1<<AW)-1];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [63:0]   pre_data = '0;
    int            we_count = 0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (sram_ce && sram_we) mem[sram_addr] <= sram_wdata;
        else if (sram_ce) sram_rdata <= mem[sram_addr];
    end

    always @(posedge clk) if (sram_we) we_count <= we_count + 1;

    logic [7:0]  ref_mem [0:127];
    logic [63:0] exp_hold;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_word(input int w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[w*8 + i];
        return v;
    endfunction

    function automatic logic [31:0] ref_load(input int a, input int nb, input logic uns);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[a + i];
        if (!uns && v[8*nb-1])
            for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_word(input int w, input logic [63:0] v);
        pre_en   = 1'b1;
        pre_addr = AW'(w);
        pre_data = v;
        for (int i = 0; i < 8; i++) ref_mem[w*8 + i] = v[8*i +: 8];
        tick;
        pre_en = 1'b0;
    endtask

    task automatic fetch(input logic [28:0] a);
        bus.isram_cs  = 1'b1;
        bus.isram_adr = a;
        #1;
        check_eq("fetch_ce", 64'(sram_ce), 64'd1);
        check_eq("fetch_addr", 64'(sram_addr), 64'(a[AW-1:0]));
        tick;
        bus.isram_cs = 1'b0;
        exp_hold = ref_word(int'(a[3:0]));
        #1;
        check_eq("fetch_data", bus.instr_fromsram, exp_hold);
        check_eq("fetch_lr", 64'(bus.lr_isram_cs), 64'd0);
    endtask

    task automatic lsu_op(input logic we, input logic [31:0] adr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wd, input logic f,
                          input logic [3:0] fw, output logic [31:0] rd_o, output logic [63:0] wr_o);
        logic mis;
        int   pre_we;
        int   a;
        int   nb;
        mis  = (size == 2'd3) || (size == 2'd1 && adr[0]) || (size == 2'd2 && adr[1:0] != 2'b00);
        a    = int'(adr[6:0]);
        nb   = 1 << size;
        rd_o = '0;
        wr_o = '0;
        bus.lsu_req      = 1'b1;
        bus.lsu_we       = we;
        bus.lsu_adr      = adr;
        bus.lsu_size     = size;
        bus.lsu_unsigned = uns;
        bus.lsu_wdata    = wd;
        bus.isram_cs     = f;
        bus.isram_adr    = {16'($urandom), 9'd0, fw};
        #1;
        check_eq("idle_ce", 64'(sram_ce), 64'(f));
        if (f) check_eq("idle_addr", 64'(sram_addr), 64'(fw));
        pre_we = we_count;
        tick;
        if (f) exp_hold = ref_word(int'(fw));
        if (mis) begin
            bus.isram_cs = 1'b0;
            bus.lsu_req  = 1'b0;
            #1;
            check_eq("mis_done", 64'(bus.lsu_done), 64'd1);
            check_eq("mis_err", 64'(bus.lsu_err), 64'd1);
            check_eq("mis_lr", 64'(bus.lr_isram_cs), 64'd0);
            check_eq("mis_ce", 64'(sram_ce), 64'd0);
            check_eq("mis_instr", bus.instr_fromsram, exp_hold);
            tick;
            check_eq("mis_done_end", 64'({bus.lsu_done, bus.lsu_err}), 64'd0);
            check_eq("mis_no_write", 64'(we_count), 64'(pre_we));
        end else begin
            bus.isram_cs  = 1'($urandom);
            bus.isram_adr = {16'($urandom), 9'd0, 4'($urandom_range(0, 15))};
            #1;
            check_eq("acc_lr", 64'({bus.lr_isram_cs, bus.lr_isram_cs_ff}), 64'b10);
            check_eq("acc_done", 64'(bus.lsu_done), 64'd0);
            check_eq("acc_ce_we", 64'({sram_ce, sram_we}), 64'b10);
            check_eq("acc_addr", 64'(sram_addr), 64'(adr[AW+2:3]));
            check_eq("acc_instr", bus.instr_fromsram, exp_hold);
            tick;
            check_eq("rsp_lr", 64'({bus.lr_isram_cs, bus.lr_isram_cs_ff}), 64'b11);
            check_eq("rsp_done", 64'({bus.lsu_done, bus.lsu_err}), 64'b10);
            check_eq("rsp_instr", bus.instr_fromsram, exp_hold);
            check_eq("rsp_ce_we", 64'({sram_ce, sram_we}), we ? 64'b11 : 64'b00);
            if (!we) begin
                rd_o = bus.lsu_rdata;
                check_eq("ld_data", 64'(rd_o), 64'(ref_load(a, nb, uns)));
            end else begin
                wr_o = sram_wdata;
                for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
                check_eq("st_word", wr_o, ref_word(a / 8));
            end
            bus.lsu_req  = 1'b0;
            bus.isram_cs = 1'b0;
            tick;
            check_eq("end_lr", 64'({bus.lr_isram_cs, bus.lr_isram_cs_ff}), 64'b01);
            check_eq("end_done", 64'(bus.lsu_done), 64'd0);
            check_eq("we_pulses", 64'(we_count - pre_we), 64'(we));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [63:0] wr;
        int          pre;
        cpurst           = 1'b1;
        bus.isram_cs     = 1'b0;
        bus.isram_adr    = '0;
        bus.lsu_req      = 1'b0;
        bus.lsu_we       = 1'b0;
        bus.lsu_adr      = '0;
        bus.lsu_size     = '0;
        bus.lsu_unsigned = 1'b0;
        bus.lsu_wdata    = '0;
        exp_hold         = '0;
        for (int w = 0; w < 16; w++) set_word(w, {$urandom, $urandom});
        tick;

        check_eq("rst_lr", 64'({bus.lr_isram_cs, bus.lr_isram_cs_ff}), 64'd0);
        check_eq("rst_done", 64'({bus.lsu_done, bus.lsu_err}), 64'd0);
        check_eq("rst_rdata", 64'(bus.lsu_rdata), 64'd0);
        check_eq("rst_sram", 64'({sram_ce, sram_we}), 64'd0);
        check_eq("rst_instr", bus.instr_fromsram, 64'd0);

        cpurst = 1'b0;
        tick;

        set_word(2, 64'h1122_3344_5566_7788);
        fetch(29'h1000_0002);
        check_eq("d_fetch", bus.instr_fromsram, 64'h1122_3344_5566_7788);

        set_word(0, 64'h0000_8000_0000_0000);
        lsu_op(1'b0, 32'h0000_0005, 2'd0, 1'b0, 32'd0, 1'b0, 4'd0, rd, wr);
        check_eq("d_ldb_signed", 64'(rd), 64'h0000_0000_FFFF_FF80);
        lsu_op(1'b0, 32'h0000_0005, 2'd0, 1'b1, 32'd0, 1'b0, 4'd0, rd, wr);
        check_eq("d_ldb_unsigned", 64'(rd), 64'h0000_0000_0000_0080);

        set_word(1, 64'hFFFF_FFFF_FFFF_FFFF);
        lsu_op(1'b1, 32'h0000_000A, 2'd1, 1'b0, 32'h0000_BEEF, 1'b0, 4'd0, rd, wr);
        check_eq("d_sth", wr, 64'hFFFF_FFFF_BEEF_FFFF);

        set_word(4, 64'hD0D0_0123_4567_89AB);
        lsu_op(1'b0, 32'h0000_0008, 2'd2, 1'b0, 32'd0, 1'b1, 4'd4, rd, wr);
        check_eq("d_ldw", 64'(rd), 64'h0000_0000_BEEF_FFFF);
        check_eq("d_fetch_held", bus.instr_fromsram, 64'hD0D0_0123_4567_89AB);

        lsu_op(1'b1, 32'h0000_0002, 2'd2, 1'b0, 32'h1234_5678, 1'b0, 4'd0, rd, wr);

        set_word(3, 64'h0123_4567_89AB_CDEF);
        pre = we_count;
        bus.lsu_req   = 1'b1;
        bus.lsu_we    = 1'b1;
        bus.lsu_adr   = 32'h0000_0018;
        bus.lsu_size  = 2'd2;
        bus.lsu_wdata = 32'hCAFE_F00D;
        tick;
        check_eq("r_acc_lr", 64'(bus.lr_isram_cs), 64'd1);
        cpurst = 1'b1;
        #1;
        check_eq("r_lr", 64'({bus.lr_isram_cs, bus.lr_isram_cs_ff}), 64'd0);
        check_eq("r_done", 64'({bus.lsu_done, bus.lsu_err}), 64'd0);
        check_eq("r_sram", 64'({sram_ce, sram_we}), 64'd0);
        check_eq("r_instr", bus.instr_fromsram, 64'd0);
        exp_hold = '0;
        tick;
        tick;
        bus.lsu_req = 1'b0;
        cpurst      = 1'b0;
        tick;
        check_eq("r_no_write", 64'(we_count), 64'(pre));
        check_eq("r_no_done", 64'(bus.lsu_done), 64'd0);
        fetch(29'h0000_0003);
        check_eq("r_fetch", bus.instr_fromsram, 64'h0123_4567_89AB_CDEF);

        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                fetch({16'($urandom), 9'd0, 4'($urandom_range(0, 15))});
            end else if (r == 2) begin
                bus.isram_cs = 1'b0;
                tick;
                check_eq("idle_instr", bus.instr_fromsram, exp_hold);
            end else begin
                lsu_op(1'($urandom), ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 127)),
                       2'($urandom_range(0, 3)), 1'($urandom), $urandom,
                       1'($urandom), 4'($urandom_range(0, 15)), rd, wr);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
